l1i_miss_queue: RTL and testbench

Tracks outstanding L1 instruction cache misses between ifetch_data_stage and l2_interface. Merges misses from different threads to the same cache line into one L2 request, issues requests one at a time over a valid/ready handshake, and wakes every waiting thread when the matching fill returns. Provides the per-thread blocked bitmap that ifetch_tag_stage uses to skip threads during thread selection.

---
 rtl/l1i_miss_queue.sv | 188 ++++++++++++++++++
 tb/tb_l1i_miss_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/l1i_miss_queue.sv
// +-----------------------------------------------------------------------------+
// | l1i_miss_queue: merges per-thread L1I misses, issues L2 fills, wakes threads |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module l1i_miss_queue #(
  parameter int THREADS           = 4,
  parameter int ADDR_WIDTH        = 32,
  parameter int LINE_OFFSET_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_miss_en,
  input  logic [ADDR_WIDTH-1:0]       i_miss_addr,
  input  logic [$clog2(THREADS)-1:0]  i_miss_thread_idx,
  output logic                        o_l2_req_valid,
  output logic [ADDR_WIDTH-1:0]       o_l2_req_addr,
  input  logic                        i_l2_req_ready,
  input  logic                        i_fill_en,
  input  logic [ADDR_WIDTH-1:0]       i_fill_addr,
  output logic [THREADS-1:0]          o_wake_oh,
  output logic [THREADS-1:0]          o_blocked_bitmap
);

  localparam int TAG_W = ADDR_WIDTH - LINE_OFFSET_WIDTH;
  localparam int IDX_W = $clog2(THREADS);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_SEND = 2'd1,
    ST_FILL = 2'd2
  } entry_state_t;

  entry_state_t               r_state   [THREADS];
  logic [TAG_W-1:0]           r_tag     [THREADS];
  logic [THREADS-1:0]         r_waiters [THREADS];
  logic                       r_req_valid;
  logic [ADDR_WIDTH-1:0]      r_req_addr;
  logic [IDX_W-1:0]           r_req_idx;
  logic [IDX_W-1:0]           r_rr_ptr;
  logic [THREADS-1:0]         r_wake;

  entry_state_t               w_state_nxt   [THREADS];
  logic [TAG_W-1:0]           w_tag_nxt     [THREADS];
  logic [THREADS-1:0]         w_waiters_nxt [THREADS];
  logic [THREADS-1:0]         w_wake_nxt;
  logic                       w_req_valid_nxt;
  logic [ADDR_WIDTH-1:0]      w_req_addr_nxt;
  logic [IDX_W-1:0]           w_req_idx_nxt;
  logic [IDX_W-1:0]           w_ptr;

  logic [TAG_W-1:0]           w_miss_tag;
  logic [TAG_W-1:0]           w_fill_tag;
  logic [THREADS-1:0]         w_thread_oh;
  logic [THREADS-1:0]         w_miss_hit;
  logic [THREADS-1:0]         w_fill_hit;
  logic                       w_handshake;
  logic                       w_alloc_found;
  logic [IDX_W-1:0]           w_alloc_idx;
  logic                       w_sel_found;
  logic [IDX_W-1:0]           w_sel_idx;
  int                         w_scan;
  logic                       w_unused_offsets;

  assign w_miss_tag       = i_miss_addr[ADDR_WIDTH-1:LINE_OFFSET_WIDTH];
  assign w_fill_tag       = i_fill_addr[ADDR_WIDTH-1:LINE_OFFSET_WIDTH];
  assign w_unused_offsets = ^{i_miss_addr[LINE_OFFSET_WIDTH-1:0], i_fill_addr[LINE_OFFSET_WIDTH-1:0]};
  assign w_thread_oh      = THREADS'(1) << i_miss_thread_idx;
  assign w_handshake      = r_req_valid && i_l2_req_ready;

  assign o_l2_req_valid = r_req_valid;
  assign o_l2_req_addr  = r_req_addr;
  assign o_wake_oh      = r_wake;

  always_comb begin
    w_miss_hit    = '0;
    w_fill_hit    = '0;
    w_alloc_found = 1'b0;
    w_alloc_idx   = '0;
    for (int e = 0; e < THREADS; e++) begin
      w_miss_hit[e] = (r_state[e] != ST_FREE) && (r_tag[e] == w_miss_tag);
      w_fill_hit[e] = (r_state[e] == ST_FILL) && (r_tag[e] == w_fill_tag);
      if (!w_alloc_found && r_state[e] == ST_FREE) begin
        w_alloc_found = 1'b1;
        w_alloc_idx   = IDX_W'(e);
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_tag_nxt       = r_tag;
    w_waiters_nxt   = r_waiters;
    w_wake_nxt      = '0;
    w_req_valid_nxt = r_req_valid;
    w_req_addr_nxt  = r_req_addr;
    w_req_idx_nxt   = r_req_idx;
    w_sel_found     = 1'b0;
    w_sel_idx       = '0;
    w_scan          = 0;

    if (w_handshake) begin
      w_state_nxt[r_req_idx] = ST_FILL;
    end

    // A miss on a line whose fill lands this cycle rides along on the wake pulse
    for (int e = 0; e < THREADS; e++) begin
      if (i_fill_en && w_fill_hit[e]) begin
        w_wake_nxt       = w_wake_nxt | r_waiters[e] | ((i_miss_en && w_miss_hit[e]) ? w_thread_oh : '0);
        w_state_nxt[e]   = ST_FREE;
        w_waiters_nxt[e] = '0;
      end else if (i_miss_en && w_miss_hit[e]) begin
        w_waiters_nxt[e] = r_waiters[e] | w_thread_oh;
      end
    end

    if (i_miss_en && !(|w_miss_hit) && w_alloc_found) begin
      w_state_nxt[w_alloc_idx]   = ST_SEND;
      w_tag_nxt[w_alloc_idx]     = w_miss_tag;
      w_waiters_nxt[w_alloc_idx] = w_thread_oh;
    end

    w_ptr = r_rr_ptr;
    if (w_handshake) begin
      w_ptr = (r_req_idx == IDX_W'(THREADS - 1)) ? '0 : r_req_idx + IDX_W'(1);
    end

    // Choosing from next-state lets a fresh allocation drive the request next cycle
    for (int k = 0; k < THREADS; k++) begin
      w_scan = (int'(w_ptr) + k) % THREADS;
      if (!w_sel_found && w_state_nxt[w_scan] == ST_SEND) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(w_scan);
      end
    end

    if (!r_req_valid || w_handshake) begin
      w_req_valid_nxt = w_sel_found;
      w_req_addr_nxt  = w_sel_found ? {w_tag_nxt[w_sel_idx], {LINE_OFFSET_WIDTH{1'b0}}} : '0;
      w_req_idx_nxt   = w_sel_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int e = 0; e < THREADS; e++) begin
        r_state[e]   <= ST_FREE;
        r_tag[e]     <= '0;
        r_waiters[e] <= '0;
      end
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_idx   <= '0;
      r_rr_ptr    <= '0;
      r_wake      <= '0;
    end else begin
      for (int e = 0; e < THREADS; e++) begin
        r_state[e]   <= w_state_nxt[e];
        r_tag[e]     <= w_tag_nxt[e];
        r_waiters[e] <= w_waiters_nxt[e];
      end
      r_req_valid <= w_req_valid_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_req_idx   <= w_req_idx_nxt;
      r_rr_ptr    <= w_ptr;
      r_wake      <= w_wake_nxt;
    end
  end

  always_comb begin
    o_blocked_bitmap = '0;
    for (int e = 0; e < THREADS; e++) begin
      if (r_state[e] != ST_FREE) begin
        o_blocked_bitmap = o_blocked_bitmap | r_waiters[e];
      end
    end
  end

  a_miss_not_blocked: assert property (@(posedge clk) disable iff (!reset)
    i_miss_en |-> !o_blocked_bitmap[i_miss_thread_idx]);

  a_miss_has_entry: assert property (@(posedge clk) disable iff (!reset)
    i_miss_en |-> ((|w_miss_hit) || w_alloc_found));

endmodule

`default_nettype wire

// File: tb/tb_l1i_miss_queue.sv
// +-----------------------------------------------------------------------------+
// | tb_l1i_miss_queue: directed vector table plus round-robin issue sequences    |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_l1i_miss_queue;

  logic        clk;
  logic        reset;
  logic        miss_en;
  logic [31:0] miss_addr;
  logic [1:0]  miss_tid;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        fill_en;
  logic [31:0] fill_addr;
  logic [3:0]  wake_oh;
  logic [3:0]  blocked;

  int n_checks;
  int n_fail;

  l1i_miss_queue #(
    .THREADS          (4),
    .ADDR_WIDTH       (32),
    .LINE_OFFSET_WIDTH(6)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_miss_en        (miss_en),
    .i_miss_addr      (miss_addr),
    .i_miss_thread_idx(miss_tid),
    .o_l2_req_valid   (req_valid),
    .o_l2_req_addr    (req_addr),
    .i_l2_req_ready   (req_ready),
    .i_fill_en        (fill_en),
    .i_fill_addr      (fill_addr),
    .o_wake_oh        (wake_oh),
    .o_blocked_bitmap (blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        men;
    logic [31:0] maddr;
    logic [1:0]  tid;
    logic        rdy;
    logic        fen;
    logic [31:0] faddr;
    logic        ev;
    logic [31:0] ea;
    logic [3:0]  ew;
    logic [3:0]  eb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic men, logic [31:0] maddr, logic [1:0] tid,
                              logic rdy, logic fen, logic [31:0] faddr,
                              logic ev, logic [31:0] ea, logic [3:0] ew, logic [3:0] eb);
    vec_t v;
    v.rst_n = rst_n; v.men = men; v.maddr = maddr; v.tid = tid; v.rdy = rdy;
    v.fen = fen; v.faddr = faddr; v.ev = ev; v.ea = ea; v.ew = ew; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic men, input logic [31:0] maddr,
                      input logic [1:0] tid, input logic rdy, input logic fen,
                      input logic [31:0] faddr);
    @(negedge clk);
    reset = rst_n; miss_en = men; miss_addr = maddr; miss_tid = tid;
    req_ready = rdy; fill_en = fen; fill_addr = faddr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b0; miss_en = 1'b0; miss_addr = '0; miss_tid = '0;
    req_ready = 1'b0; fill_en = 1'b0; fill_addr = '0;

    //              rst men maddr     tid rdy fen faddr      ev ea         ew       eb
    vecs.push_back(mk(0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0000));
    vecs.push_back(mk(0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0000));
    // single miss, ready held low three cycles, fill with offset bits set
    vecs.push_back(mk(1, 1, 32'h1000, 1, 0, 0, 32'h0,    1, 32'h1000, 4'b0000, 4'b0010));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 0, 32'h0,    1, 32'h1000, 4'b0000, 4'b0010));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 0, 32'h0,    1, 32'h1000, 4'b0000, 4'b0010));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 0, 32'h0,    1, 32'h1000, 4'b0000, 4'b0010));
    vecs.push_back(mk(1, 0, 32'h0,    0, 1, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0010));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0010));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0010));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0010));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 1, 32'h103C, 0, 32'h0,    4'b0010, 4'b0000));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0000));
    // merge: two threads on one line, a single request
    vecs.push_back(mk(1, 1, 32'h2040, 0, 0, 0, 32'h0,    1, 32'h2040, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 0, 32'h0,    1, 32'h2040, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 1, 32'h2040, 2, 0, 0, 32'h0,    1, 32'h2040, 4'b0000, 4'b0101));
    vecs.push_back(mk(1, 0, 32'h0,    0, 1, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0101));
    vecs.push_back(mk(1, 0, 32'h0,    0, 1, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0101));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 1, 32'h2040, 0, 32'h0,    4'b0101, 4'b0000));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0000));
    // same-cycle miss and fill on the same line
    vecs.push_back(mk(1, 1, 32'h3000, 0, 0, 0, 32'h0,    1, 32'h3000, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 0, 32'h0,    0, 1, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0001));
    vecs.push_back(mk(1, 1, 32'h3000, 3, 0, 1, 32'h3000, 0, 32'h0,    4'b1001, 4'b0000));
    vecs.push_back(mk(1, 0, 32'h0,    0, 1, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0000));
    // stray fill, then reset with two lines in FILL and late fills afterwards
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 1, 32'h5000, 0, 32'h0,    4'b0000, 4'b0000));
    vecs.push_back(mk(1, 1, 32'h6000, 1, 0, 0, 32'h0,    1, 32'h6000, 4'b0000, 4'b0010));
    vecs.push_back(mk(1, 1, 32'h7000, 2, 1, 0, 32'h0,    1, 32'h7000, 4'b0000, 4'b0110));
    vecs.push_back(mk(1, 0, 32'h0,    0, 1, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0110));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 1, 32'h5000, 0, 32'h0,    4'b0000, 4'b0110));
    vecs.push_back(mk(1, 1, 32'h8000, 0, 0, 0, 32'h0,    1, 32'h8000, 4'b0000, 4'b0111));
    vecs.push_back(mk(0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0000));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 1, 32'h6000, 0, 32'h0,    4'b0000, 4'b0000));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 1, 32'h7000, 0, 32'h0,    4'b0000, 4'b0000));
    // fill and different-tag miss together; freed entry reused next cycle
    vecs.push_back(mk(1, 1, 32'h8000, 0, 0, 0, 32'h0,    1, 32'h8000, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 0, 32'h0,    0, 1, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0001));
    vecs.push_back(mk(1, 1, 32'h9000, 1, 0, 1, 32'h8000, 1, 32'h9000, 4'b0001, 4'b0010));
    vecs.push_back(mk(1, 1, 32'hA000, 0, 0, 0, 32'h0,    1, 32'h9000, 4'b0000, 4'b0011));
    vecs.push_back(mk(1, 0, 32'h0,    0, 1, 0, 32'h0,    1, 32'hA000, 4'b0000, 4'b0011));
    vecs.push_back(mk(1, 0, 32'h0,    0, 1, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0011));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 1, 32'h9000, 0, 32'h0,    4'b0010, 4'b0001));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 1, 32'hA000, 0, 32'h0,    4'b0001, 4'b0000));
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,    4'b0000, 4'b0000));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].men, vecs[i].maddr, vecs[i].tid,
           vecs[i].rdy, vecs[i].fen, vecs[i].faddr);
      chk($sformatf("vec%0d l2_req_valid", i), {31'd0, req_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev || !vecs[i].rst_n)
        chk($sformatf("vec%0d l2_req_addr", i), req_addr, vecs[i].ea);
      chk($sformatf("vec%0d wake_oh", i), {28'd0, wake_oh}, {28'd0, vecs[i].ew});
      chk($sformatf("vec%0d blocked", i), {28'd0, blocked}, {28'd0, vecs[i].eb});
    end

    // round-robin: four distinct lines queued, then granted in entry order; twice
    for (int round = 0; round < 2; round++) begin
      for (int k = 0; k < 4; k++) begin
        step(1'b1, 1'b1, 32'(k * 32'h40), 2'(k), 1'b0, 1'b0, 32'h0);
        chk($sformatf("rr%0d queue%0d valid", round, k), {31'd0, req_valid}, 32'd1);
        chk($sformatf("rr%0d queue%0d addr", round, k), req_addr, 32'h0);
        chk($sformatf("rr%0d queue%0d blocked", round, k), {28'd0, blocked}, 32'((1 << (k + 1)) - 1));
      end
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("rr%0d grant%0d valid", round, g), {31'd0, req_valid}, 32'd1);
        chk($sformatf("rr%0d grant%0d addr", round, g), req_addr, 32'(g * 32'h40));
        step(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
      end
      chk($sformatf("rr%0d drained valid", round), {31'd0, req_valid}, 32'd0);
      chk($sformatf("rr%0d drained blocked", round), {28'd0, blocked}, 32'hF);
      for (int k = 0; k < 4; k++) begin
        step(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'(k * 32'h40));
        chk($sformatf("rr%0d fill%0d wake", round, k), {28'd0, wake_oh}, 32'(1 << k));
      end
      step(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("rr%0d idle wake", round), {28'd0, wake_oh}, 32'd0);
      chk($sformatf("rr%0d idle blocked", round), {28'd0, blocked}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
